// File: rtl/next_pc_sequencer_if.sv
// Fetch-loop bundle between the next-PC sequencer (master) and the ProgramCounter side (slave).
interface next_pc_sequencer_if;
  logic [31:0] outPC;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] nextPC;
  logic        holdPC;
  logic        flush;
  logic        misalign_err;

  modport master (
    input  outPC, stall, imem_ready, branch_taken, branch_target, jump, jump_target,
    output nextPC, holdPC, flush, misalign_err
  );

  modport slave (
    output outPC, stall, imem_ready, branch_taken, branch_target, jump, jump_target,
    input  nextPC, holdPC, flush, misalign_err
  );
endinterface

// File: rtl/next_pc_sequencer.sv
// Next-PC selection for the fetch loop: sequential, branch, jump or parked redirect, plus hold/flush.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module next_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'hFFFF_FFFC,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic                 clk,
  input logic                 Reset,
  next_pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {StRst, StRun, StWait} state_e;

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        redirect;
  logic [31:0] live_tgt;
  logic [31:0] sel_tgt;
  logic [31:0] applied_pc;
  logic        applied_mis;

  // Branch resolves in EX, so it is older than an ID-stage jump and wins.
  assign redirect = bus.branch_taken | bus.jump;
  assign live_tgt = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign sel_tgt  = redirect ? live_tgt : pend_pc_q;

`ifdef PC_ALIGN_CHECK_EN
  assign applied_pc  = {sel_tgt[31:2], 2'b00};
  assign applied_mis = |sel_tgt[1:0];
`else
  assign applied_pc  = sel_tgt;
  assign applied_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= StRst;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    unique case (state_q)
      StRst: state_d = StRun;
      StRun, StWait: begin
        if (!bus.imem_ready) begin
          state_d = StWait;
          // Park the newest redirect until the fetch unblocks.
          if (redirect) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = live_tgt;
          end
        end else begin
          state_d      = StRun;
          pend_valid_d = 1'b0;
        end
      end
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    bus.nextPC       = bus.outPC;
    bus.holdPC       = 1'b1;
    bus.flush        = 1'b0;
    bus.misalign_err = 1'b0;
    unique case (state_q)
      StRst: begin
        bus.nextPC = RESET_PC;
        bus.holdPC = 1'b0;
        bus.flush  = 1'b1;
      end
      StRun, StWait: begin
        if (bus.imem_ready) begin
          // A redirect squashes the stalled instruction, so it overrides stall.
          if (redirect || pend_valid_q) begin
            bus.nextPC       = applied_pc;
            bus.holdPC       = 1'b0;
            bus.flush        = 1'b1;
            bus.misalign_err = applied_mis;
          end else if (!bus.stall) begin
            bus.nextPC = bus.outPC + PC_STEP;
            bus.holdPC = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Scoreboard bench for next_pc_sequencer with a behavioural ProgramCounter closing the fetch loop.
module tb_next_pc_sequencer;

  logic clk = 1'b0;
  logic Reset;

  next_pc_sequencer_if bus ();

  next_pc_sequencer dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ProgramCounter model: loads nextPC unless held.
  always_ff @(posedge clk) begin
    if (!bus.holdPC) bus.outPC <= bus.nextPC;
  end

  typedef struct {
    logic [31:0] nxt;
    logic        hold;
    logic        flush;
    logic        err;
    logic [31:0] pc;
    bit          chk_pc;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] MisPc  = 32'h0000_0100;
  localparam logic        MisErr = 1'b1;
`else
  localparam logic [31:0] MisPc  = 32'h0000_0102;
  localparam logic        MisErr = 1'b0;
`endif

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Monitor: compare the presented outputs every cycle a stimulus is outstanding.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("nextPC", e.id, bus.nextPC, e.nxt);
      check("holdPC", e.id, {31'd0, bus.holdPC}, {31'd0, e.hold});
      check("flush", e.id, {31'd0, bus.flush}, {31'd0, e.flush});
      check("misalign_err", e.id, {31'd0, bus.misalign_err}, {31'd0, e.err});
      if (e.chk_pc) check("outPC", e.id, bus.outPC, e.pc);
    end
  end

  task automatic step(input logic rst, input logic rdy, input logic stl, input logic bt,
                      input logic [31:0] btg, input logic jp, input logic [31:0] jtg,
                      input logic [31:0] e_next, input logic e_hold, input logic e_flush,
                      input logic e_err, input logic [31:0] e_pc, input bit chk_pc);
    exp_t e;
    @(posedge clk);
    #1;
    Reset             = rst;
    bus.imem_ready    = rdy;
    bus.stall         = stl;
    bus.branch_taken  = bt;
    bus.branch_target = btg;
    bus.jump          = jp;
    bus.jump_target   = jtg;
    step_id++;
    e.nxt = e_next; e.hold = e_hold; e.flush = e_flush; e.err = e_err;
    e.pc = e_pc; e.chk_pc = chk_pc; e.id = step_id;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    bus.imem_ready = 1'b1; bus.stall = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    bus.jump = 1'b0; bus.jump_target = 32'd0;

    // Reset, then sequential walk with wraparound from the reset PC.
    step(1, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 0, 32'h0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 0, 32'hFFFF_FFFC, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 0, 32'hFFFF_FFFC, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 32'hFFFF_FFFC, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0000_0004, 0, 0, 0, 32'h0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0000_0008, 0, 0, 0, 32'h4, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0000_000C, 0, 0, 0, 32'h8, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0000_0010, 0, 0, 0, 32'hC, 1);
    // Jump to 0x40, stall two cycles, release.
    step(0, 1, 0, 0, 0, 1, 32'h40, 32'h40, 0, 1, 0, 32'h10, 1);
    step(0, 1, 1, 0, 0, 0, 0, 32'h40, 1, 0, 0, 32'h40, 1);
    step(0, 1, 1, 0, 0, 0, 0, 32'h40, 1, 0, 0, 32'h40, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0, 32'h40, 1);
    // Branch beats jump and overrides stall.
    step(0, 1, 0, 0, 0, 1, 32'h40, 32'h40, 0, 1, 0, 32'h44, 1);
    step(0, 1, 1, 1, 32'h100, 1, 32'h200, 32'h100, 0, 1, 0, 32'h40, 1);
    // Wait states with parked redirect, last one wins.
    step(0, 1, 0, 0, 0, 1, 32'h80, 32'h80, 0, 1, 0, 32'h100, 1);
    step(0, 0, 0, 0, 0, 1, 32'h300, 32'h80, 1, 0, 0, 32'h80, 1);
    step(0, 0, 0, 0, 0, 0, 0, 32'h80, 1, 0, 0, 32'h80, 1);
    step(0, 0, 0, 0, 0, 0, 0, 32'h80, 1, 0, 0, 32'h80, 1);
    step(0, 0, 0, 1, 32'h400, 0, 0, 32'h80, 1, 0, 0, 32'h80, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h400, 0, 1, 0, 32'h80, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h404, 0, 0, 0, 32'h400, 1);
    // Live redirect beats the parked one on the ready cycle.
    step(0, 0, 0, 0, 0, 1, 32'h500, 32'h404, 1, 0, 0, 32'h404, 1);
    step(0, 1, 0, 1, 32'h600, 0, 0, 32'h600, 0, 1, 0, 32'h404, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h604, 0, 0, 0, 32'h600, 1);
    // Misaligned branch target.
    step(0, 1, 0, 1, 32'h102, 0, 0, MisPc, 0, 1, MisErr, 32'h604, 1);
    step(0, 1, 0, 0, 0, 0, 0, MisPc + 32'd4, 0, 0, 0, MisPc, 1);
    // Reset during WAIT discards the parked target.
    step(0, 0, 0, 0, 0, 1, 32'h700, MisPc + 32'd4, 1, 0, 0, MisPc + 32'd4, 1);
    step(1, 0, 0, 0, 0, 0, 0, MisPc + 32'd4, 1, 0, 0, MisPc + 32'd4, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 0, MisPc + 32'd4, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'hFFFF_FFFC, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0, 32'h0, 1);
    // WAIT exit with no parked target falls back to stall/sequential.
    step(0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0, 32'h4, 1);
    step(0, 1, 1, 0, 0, 0, 0, 32'h4, 1, 0, 0, 32'h4, 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h8, 0, 0, 0, 32'h4, 1);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
